// File: rtl/branch_predictor_pkg.sv
// Shared ISA encodings and PHT counter constants for the branch predictor.
// Pure declarations: no latency and no backpressure apply here.
package branch_predictor_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // Weakly not-taken: MSB clear, every lower bit set.
    function automatic int ctr_init(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

endpackage

// File: rtl/branch_outcome.sv
// Decodes an EX instruction plus the ALU zero flag into branch / actual-direction.
// Latency: purely combinational; no backpressure, unrecognised encodings give 0/0.
module branch_outcome
    import branch_predictor_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        alu_zero,
    output logic        is_branch,
    output logic        taken
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic       set;
    logic       unused_fields;

    assign opcode        = instruction[31:26];
    assign rt            = instruction[20:16];
    assign set           = ~alu_zero;
    assign unused_fields = ^{instruction[25:21], instruction[15:0]};

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        case (opcode)
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ, RT_BLTZAL: begin
                        is_branch = 1'b1;
                        taken     = set;
                    end
                    RT_BGEZ, RT_BGEZAL: begin
                        is_branch = 1'b1;
                        taken     = ~set;
                    end
                    default: ;
                endcase
            end
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = alu_zero;
            end
            OP_BNE: begin
                is_branch = 1'b1;
                taken     = ~alu_zero;
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                taken     = set;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                taken     = ~set;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor: PHT of saturating counters, history and perf counters.
// Latency: zero-cycle predict and resolve, PHT/GHR/perf update on the next edge; never stalls.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PHT_BITS   = 6,
    parameter int CTR_WIDTH  = 2,
    parameter int GHR_BITS   = 0,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pred_pc,
    output logic                  pred_taken,
    output logic [PHT_BITS-1:0]   pred_index,
    input  logic                  res_valid,
    input  logic [31:0]           res_instruction,
    input  logic                  res_aluZero,
    input  logic                  res_pred_taken,
    input  logic [PHT_BITS-1:0]   res_index,
    output logic                  res_is_branch,
    output logic                  res_taken,
    output logic                  mispredict,
    output logic [PERF_WIDTH-1:0] perf_branches,
    output logic [PERF_WIDTH-1:0] perf_mispredicts
);

    localparam int                   PHT_ENTRIES = 1 << PHT_BITS;
    localparam logic [CTR_WIDTH-1:0] CTR_RST     = CTR_WIDTH'(ctr_init(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_MAX     = '1;

    logic [CTR_WIDTH-1:0] pht [PHT_ENTRIES];
    logic [PHT_BITS-1:0]  hist;
    logic                 upd;
    logic                 unused_pc;

    assign unused_pc = ^{pred_pc[31:PHT_BITS+2], pred_pc[1:0]};

    branch_outcome u_outcome (
        .instruction (res_instruction),
        .alu_zero    (res_aluZero),
        .is_branch   (res_is_branch),
        .taken       (res_taken)
    );

    assign upd        = res_valid & res_is_branch;
    assign mispredict = upd & (res_taken != res_pred_taken);

    // History is trained only at resolve, so wrong-path fetches never pollute it.
    generate
        if (GHR_BITS > 0) begin : g_gshare
            logic [GHR_BITS-1:0] ghr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr <= '0;
                end else if (upd) begin
                    ghr <= (ghr << 1) | GHR_BITS'(res_taken);
                end
            end
            assign hist = PHT_BITS'(ghr);
        end else begin : g_bimodal
            assign hist = '0;
        end
    endgenerate

    assign pred_index = pred_pc[PHT_BITS+1:2] ^ hist;
    // No bypass: a same-index update this cycle is visible only after the edge.
    assign pred_taken = pht[pred_index][CTR_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CTR_RST;
            end
        end else if (upd) begin
            if (res_taken) begin
                if (pht[res_index] != CTR_MAX) begin
                    pht[res_index] <= pht[res_index] + 1'b1;
                end
            end else if (pht[res_index] != '0) begin
                pht[res_index] <= pht[res_index] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (upd && !(&perf_branches)) begin
                perf_branches <= perf_branches + 1'b1;
            end
            if (mispredict && !(&perf_mispredicts)) begin
                perf_mispredicts <= perf_mispredicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: bimodal instance, gshare instance and a narrow-perf instance.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bimodal instance A and narrow-perf instance C share stimulus.
    logic [31:0] a_pc, a_ins;
    logic        a_az, a_pt, a_vld;
    logic [5:0]  a_idx;
    logic        a_pred, a_isb, a_tk, a_mp;
    logic [5:0]  a_pidx;
    logic [31:0] a_pb, a_pm;
    logic        c_pred, c_isb, c_tk, c_mp;
    logic [5:0]  c_pidx;
    logic [3:0]  c_pb, c_pm;

    logic [31:0] b_pc, b_ins;
    logic        b_az, b_pt, b_vld;
    logic [5:0]  b_idx;
    logic        b_pred, b_isb, b_tk, b_mp;
    logic [5:0]  b_pidx;
    logic [31:0] b_pb, b_pm;

    branch_predictor dut_a (
        .clk(clk), .rst_n(rst_n), .pred_pc(a_pc), .pred_taken(a_pred), .pred_index(a_pidx),
        .res_valid(a_vld), .res_instruction(a_ins), .res_aluZero(a_az), .res_pred_taken(a_pt),
        .res_index(a_idx), .res_is_branch(a_isb), .res_taken(a_tk), .mispredict(a_mp),
        .perf_branches(a_pb), .perf_mispredicts(a_pm)
    );

    branch_predictor #(.GHR_BITS(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .pred_pc(b_pc), .pred_taken(b_pred), .pred_index(b_pidx),
        .res_valid(b_vld), .res_instruction(b_ins), .res_aluZero(b_az), .res_pred_taken(b_pt),
        .res_index(b_idx), .res_is_branch(b_isb), .res_taken(b_tk), .mispredict(b_mp),
        .perf_branches(b_pb), .perf_mispredicts(b_pm)
    );

    branch_predictor #(.PERF_WIDTH(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .pred_pc(a_pc), .pred_taken(c_pred), .pred_index(c_pidx),
        .res_valid(a_vld), .res_instruction(a_ins), .res_aluZero(a_az), .res_pred_taken(a_pt),
        .res_index(a_idx), .res_is_branch(c_isb), .res_taken(c_tk), .mispredict(c_mp),
        .perf_branches(c_pb), .perf_mispredicts(c_pm)
    );

    localparam logic [31:0] I_BEQ    = 32'h1000_0000;
    localparam logic [31:0] I_BNE    = 32'h1400_0000;
    localparam logic [31:0] I_BLEZ   = 32'h1800_0000;
    localparam logic [31:0] I_BGTZ   = 32'h1C00_0000;
    localparam logic [31:0] I_BLTZ   = 32'h0400_0000;
    localparam logic [31:0] I_BGEZ   = 32'h0401_0000;
    localparam logic [31:0] I_BLTZAL = 32'h0410_0000;
    localparam logic [31:0] I_BGEZAL = 32'h0411_0000;
    localparam logic [31:0] I_RIBAD  = 32'h0403_0000;
    localparam logic [31:0] I_ADDU   = 32'h0022_1821;

    // Gshare training: BNE taken, BLTZ not-taken, BGEZ taken, BLEZ taken.
    logic [31:0] gs_ins [4] = '{I_BNE, I_BLTZ, I_BGEZ, I_BLEZ};
    logic        gs_az  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        gs_tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [5:0]  gs_idx [4] = '{6'h11, 6'h12, 6'h15, 6'h1B};

    // Index-4 counter walk from 01: 10,11,11,11 then 10,01.
    logic tb_az   [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic tb_pre  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic tb_mp   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic tb_post [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Decode-only vectors with res_valid low.
    logic [31:0] dc_ins [5] = '{I_BGTZ, I_BLEZ, I_BLTZAL, I_BGEZAL, I_BNE};
    logic        dc_az  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        dc_tk  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        a_pc = 32'h0040_0000; a_ins = '0; a_az = 1'b0; a_pt = 1'b0; a_vld = 1'b0; a_idx = '0;
        b_pc = 32'h0000_0040; b_ins = '0; b_az = 1'b0; b_pt = 1'b0; b_vld = 1'b0; b_idx = '0;

        #2;
        check("rst_pred", a_pred, 1'b0);
        check("rst_pb", a_pb, 0);
        check("rst_pm", a_pm, 0);
        check("rst_c_perf", {c_pb, c_pm}, 8'h00);
        check("rst_b_idx", b_pidx, 6'h10);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b_vld = 1'b1; b_ins = gs_ins[i]; b_az = gs_az[i];
            #1;
            check("gs_isb", b_isb, 1'b1);
            check("gs_taken", b_tk, gs_tk[i]);
            @(posedge clk);
            #1;
            check("gs_index", b_pidx, gs_idx[i]);
        end
        @(negedge clk);
        b_vld = 1'b0;
        @(posedge clk);
        #1;
        check("gs_idle_index", b_pidx, 6'h1B);

        @(negedge clk);
        a_pc = 32'h0040_0010;
        #1;
        check("idx4", a_pidx, 6'd4);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_vld = 1'b1; a_ins = I_BEQ; a_az = tb_az[i]; a_idx = 6'd4; a_pt = tb_pre[i];
            #1;
            check("beq_pre_pred", a_pred, tb_pre[i]);
            check("beq_mispredict", a_mp, tb_mp[i]);
            @(posedge clk);
            #1;
            check("beq_post_pred", a_pred, tb_post[i]);
            if (i == 3) begin
                check("pb_after4", a_pb, 4);
                check("pm_after4", a_pm, 1);
                check("c_perf_after4", {c_pb, c_pm}, 8'h41);
            end
        end

        @(negedge clk);
        a_ins = I_RIBAD; a_az = 1'b0; a_pt = 1'b1;
        #1;
        check("ri_isb", a_isb, 1'b0);
        check("ri_taken", a_tk, 1'b0);
        check("ri_mp", a_mp, 1'b0);
        @(negedge clk);
        a_ins = I_ADDU; a_az = 1'b1;
        #1;
        check("addu_isb", a_isb, 1'b0);
        check("addu_taken", a_tk, 1'b0);
        @(negedge clk);
        a_vld = 1'b0; a_ins = I_BEQ; a_az = 1'b1; a_pt = 1'b0;
        #1;
        check("novld_mp", a_mp, 1'b0);
        @(posedge clk);
        #1;
        check("nochg_pb", a_pb, 6);
        check("nochg_pm", a_pm, 3);
        check("nochg_pred", a_pred, 1'b0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_ins = dc_ins[i]; a_az = dc_az[i]; a_pt = ~dc_tk[i];
            #1;
            check("dec_isb", a_isb, 1'b1);
            check("dec_taken", a_tk, dc_tk[i]);
            check("dec_mp", a_mp, 1'b0);
        end

        @(negedge clk);
        a_vld = 1'b1; a_ins = I_BEQ; a_az = 1'b1; a_pt = 1'b0; a_idx = 6'd8;
        repeat (20) @(posedge clk);
        #1;
        check("pb_26", a_pb, 26);
        check("pm_23", a_pm, 23);
        check("c_pb_sat", c_pb, 4'hF);
        check("c_pm_sat", c_pm, 4'hF);

        @(negedge clk);
        a_idx = 6'd4;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mp", a_mp, 1'b1);
        check("rst_mid_pb", a_pb, 0);
        @(posedge clk);
        #1;
        check("rst_mid_pred", a_pred, 1'b0);
        check("rst_mid_pm", a_pm, 0);
        @(negedge clk);
        a_vld = 1'b0;
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
